// File: rtl/pitch_fr3_search_pkg.sv
// Shared constants, FSM encoding and fixed-point helpers for the G.729
// closed-loop fractional pitch search.
package pitch_fr3_search_pkg;

  // Scratch-memory address of corr_v for lag t0Min-4
  localparam logic [11:0] PITCH_FR3_CORR_V = 12'h100;

  localparam int L_INTER4 = 4;
  localparam int UP_SAMP  = 3;

  // Subframe-0 lags above this skip the fractional search
  localparam logic [15:0] T0_SHORTCUT = 16'd84;

  typedef enum logic [3:0] {
    S_IDLE, S_MAX_RD, S_MAX_CMP, S_CHECK, S_INT_RD,
    S_INT_MAC, S_INT_RND, S_FIX, S_DONE
  } state_e;

  // inter_3 interpolation filter (1/3 resolution), 13 taps
  function automatic logic signed [15:0] inter3(input logic [3:0] idx);
    case (idx)
      4'd0:    return 16'sd29443;
      4'd1:    return 16'sd25207;
      4'd2:    return 16'sd14701;
      4'd3:    return 16'sd3143;
      4'd4:    return -16'sd4402;
      4'd5:    return -16'sd5850;
      4'd6:    return -16'sd2783;
      4'd7:    return 16'sd1211;
      4'd8:    return 16'sd3130;
      4'd9:    return 16'sd2259;
      4'd11:   return -16'sd1652;
      4'd12:   return -16'sd1666;
      default: return 16'sd0;
    endcase
  endfunction

  // 32-bit saturating add (ITU L_add)
  function automatic logic signed [31:0] l_add(input logic signed [31:0] a,
                                               input logic signed [31:0] b);
    logic signed [32:0] s;
    s = {a[31], a} + {b[31], b};
    if (s[32] != s[31]) return s[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
    return s[31:0];
  endfunction

endpackage

// File: rtl/interpol3_mac.sv
// Interpol_3 datapath: inter_3 ROM, 16x16 L_mult, saturating L_mac
// accumulator and ITU round of the accumulated value.
module interpol3_mac
  import pitch_fr3_search_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clr_i,
  input  logic               acc_i,
  input  logic [1:0]         fe_i,
  input  logic [2:0]         k_i,
  input  logic signed [15:0] x_i,
  output logic signed [15:0] rnd_o
);

  logic signed [31:0] acc_q, acc_d;
  logic signed [31:0] prod, lmult, rsum;
  logic signed [15:0] coef;
  logic [3:0]         idx;

  // Even terms walk back from p with inter_3[fe+3i]; odd terms walk
  // forward from p+1 with inter_3[3-fe+3i]
  always_comb begin
    idx = '0;
    if (k_i[0]) idx = 4'(UP_SAMP - int'(fe_i) + UP_SAMP * int'(k_i[2:1]));
    else        idx = 4'(int'(fe_i) + UP_SAMP * int'(k_i[2:1]));
    coef  = inter3(idx);
    prod  = 32'(x_i) * 32'(coef);
    lmult = (x_i == 16'sh8000 && coef == 16'sh8000) ? 32'sh7FFF_FFFF : (prod <<< 1);
    acc_d = acc_q;
    if (clr_i)      acc_d = '0;
    else if (acc_i) acc_d = l_add(acc_q, lmult);
    rsum  = l_add(acc_q, 32'sh0000_8000);
    rnd_o = rsum[31:16];
  end

  // Accumulator register
  always_ff @(posedge clk) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

endmodule

// File: rtl/pitch_fr3_search.sv
// G.729 Pitch_fr3: integer max search over corr_v followed by 1/3
// fractional refinement with Interpol_3, bit-exact with the ITU C code.
module pitch_fr3_search
  import pitch_fr3_search_pkg::*;
#(
  parameter logic [11:0] CORR_BASE = PITCH_FR3_CORR_V
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] t0Min,
  input  logic [15:0] t0Max,
  input  logic        firstSubfr,
  output logic [11:0] memReadAddr,
  input  logic [31:0] memIn,
  output logic [15:0] t0,
  output logic [15:0] frac,
  output logic        done
);

  state_e             state_q;
  logic [15:0]        tmin_q, tmax_q, lag_q, t0_q;
  logic               first_q, done_q;
  logic signed [15:0] maxv_q;
  logic signed [2:0]  fi_q, frac_q;
  logic [2:0]         k_q;
  logic [11:0]        addr_q;

  logic signed [15:0] corr, rnd;
  logic [15:0]        off;
  logic [1:0]         fe;
  logic               unused_hi;

  assign corr      = memIn[15:0];
  assign unused_hi = ^memIn[31:16];
  assign off       = t0_q - tmin_q;
  assign fe        = fi_q[2] ? 2'(fi_q + 3'sd3) : 2'(fi_q);

  assign memReadAddr = addr_q;
  assign t0          = t0_q;
  assign frac        = {{13{frac_q[2]}}, frac_q};
  assign done        = done_q;

  // Address of Interpol_3 term k for fraction f around lag t0 (off = t0-t0Min)
  function automatic logic [11:0] int_addr(input logic [15:0] o,
                                           input logic signed [2:0] f,
                                           input logic [2:0] k);
    logic [15:0] a;
    a = o + 16'd4;
    if (f[2]) a = a - 16'd1;
    if (k[0]) a = a + 16'd1 + {14'd0, k[2:1]};
    else      a = a - {14'd0, k[2:1]};
    return CORR_BASE + a[11:0];
  endfunction

  interpol3_mac u_mac (
    .clk   (clk),
    .reset (reset),
    .clr_i (state_q == S_CHECK || state_q == S_INT_RND),
    .acc_i (state_q == S_INT_MAC),
    .fe_i  (fe),
    .k_i   (k_q),
    .x_i   (corr),
    .rnd_o (rnd)
  );

  // Search sequencer; max register is shared by the integer and fractional phases
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      tmin_q  <= '0;
      tmax_q  <= '0;
      lag_q   <= '0;
      t0_q    <= '0;
      first_q <= 1'b0;
      done_q  <= 1'b0;
      maxv_q  <= '0;
      fi_q    <= '0;
      frac_q  <= '0;
      k_q     <= '0;
      addr_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: if (start) begin
          tmin_q  <= t0Min;
          tmax_q  <= t0Max;
          first_q <= firstSubfr;
          lag_q   <= t0Min;
          t0_q    <= t0Min;
          frac_q  <= '0;
          maxv_q  <= 16'sh8000;          // first compare always wins
          addr_q  <= CORR_BASE + 12'd4;
          done_q  <= 1'b0;
          state_q <= S_MAX_RD;
        end
        S_MAX_RD: state_q <= S_MAX_CMP;
        S_MAX_CMP: begin
          if (corr >= maxv_q) begin       // ties move to the later lag
            maxv_q <= corr;
            t0_q   <= lag_q;
          end
          if (lag_q == tmax_q) state_q <= S_CHECK;
          else begin
            lag_q   <= lag_q + 16'd1;
            addr_q  <= addr_q + 12'd1;
            state_q <= S_MAX_RD;
          end
        end
        S_CHECK: begin
          if (first_q && t0_q > T0_SHORTCUT) begin
            frac_q  <= '0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            fi_q    <= -3'sd2;
            k_q     <= '0;
            addr_q  <= int_addr(off, -3'sd2, 3'd0);
            state_q <= S_INT_RD;
          end
        end
        S_INT_RD: state_q <= S_INT_MAC;
        S_INT_MAC: begin
          if (k_q == 3'(2 * L_INTER4 - 1)) state_q <= S_INT_RND;
          else begin
            k_q     <= k_q + 3'd1;
            addr_q  <= int_addr(off, fi_q, k_q + 3'd1);
            state_q <= S_INT_RD;
          end
        end
        S_INT_RND: begin
          if (fi_q == -3'sd2 || rnd > maxv_q) begin
            maxv_q <= rnd;
            frac_q <= fi_q;
          end
          if (fi_q == 3'sd2) state_q <= S_FIX;
          else begin
            fi_q    <= fi_q + 3'sd1;
            k_q     <= '0;
            addr_q  <= int_addr(off, fi_q + 3'sd1, 3'd0);
            state_q <= S_INT_RD;
          end
        end
        S_FIX: begin
          if (frac_q == -3'sd2) begin
            frac_q <= 3'sd1;
            t0_q   <= t0_q - 16'd1;
          end else if (frac_q == 3'sd2) begin
            frac_q <= -3'sd1;
            t0_q   <= t0_q + 16'd1;
          end
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pitch_fr3_search.sv
// Directed bench for pitch_fr3_search: corr_v scratch memory model plus
// hand-computed t0/frac/latency expectations.
module tb_pitch_fr3_search;
  import pitch_fr3_search_pkg::*;

  logic        clk, reset, start, firstSubfr, done;
  logic [15:0] t0Min, t0Max, t0, frac;
  logic [11:0] memReadAddr;
  logic [31:0] memIn;

  logic signed [15:0] corr [0:255];
  int cur_tmin;
  int n_chk, n_pass;

  pitch_fr3_search dut (
    .clk(clk), .reset(reset), .start(start), .t0Min(t0Min), .t0Max(t0Max),
    .firstSubfr(firstSubfr), .memReadAddr(memReadAddr), .memIn(memIn),
    .t0(t0), .frac(frac), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scratch memory: one-cycle read latency, garbage in the upper half-word
  always @(posedge clk)
    memIn <= {16'hA5A5, corr[8'(int'(memReadAddr) - int'(PITCH_FR3_CORR_V) + cur_tmin - 4)]};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
  endtask

  task automatic clr();
    for (int i = 0; i < 256; i++) corr[i] = 16'sd0;
  endtask

  task automatic run(input string tag, input int tmin, input int tmax, input logic first,
                     input int et0, input int efrac, input int elat, input int busy_at);
    int cyc;
    cur_tmin   = tmin;
    t0Min      = 16'(tmin);
    t0Max      = 16'(tmax);
    firstSubfr = first;
    start      = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
    t0Min      = 16'hFFFF;
    t0Max      = 16'h0000;
    firstSubfr = ~first;
    cyc = 1;
    chk({tag, ".done_drop"}, {31'd0, done}, 32'd0);
    while (!done && cyc < 1000) begin
      start = (cyc == busy_at);
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk({tag, ".lat"}, cyc, elat);
    chk({tag, ".t0"}, {16'd0, t0}, et0);
    chk({tag, ".frac"}, {16'd0, frac}, {16'd0, 16'(efrac)});
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    clr();
    cur_tmin = 0;
    reset = 1'b1; start = 1'b0; t0Min = '0; t0Max = '0; firstSubfr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.addr", {20'd0, memReadAddr}, 32'd0);
    chk("rst.t0", {16'd0, t0}, 32'd0);
    chk("rst.frac", {16'd0, frac}, 32'd0);
    chk("rst.done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Unit peak: interpolated -2..2 = 7351,12604,14722,12604,7351 -> f=0
    corr[50] = 16'sh4000;
    run("unit", 40, 60, 1'b0, 50, 0, 2*21+88, 0);

    // Subframe-0 shortcut, no reads after the max loop
    clr(); corr[100] = 16'sh2000;
    run("short", 20, 143, 1'b1, 100, 0, 250, 0);
    chk("short.addr", {20'd0, memReadAddr}, 32'(PITCH_FR3_CORR_V) + 32'd127);

    // Flat plateau: later lag wins the tie
    clr(); for (int i = 90; i <= 100; i++) corr[i] = 16'sh1000;
    run("tie", 80, 110, 1'b1, 100, 0, 2*31+2, 0);

    // Threshold: lag 84 still searched, lag 85 takes the shortcut
    clr(); corr[84] = 16'sh4000;
    run("lag84", 70, 100, 1'b1, 84, 0, 2*31+88, 0);
    clr(); corr[85] = 16'sh4000;
    run("lag85", 70, 100, 1'b1, 85, 0, 2*31+2, 0);

    // Signed compare: 100 beats -5 (0xFFFB)
    clr(); corr[88] = 16'sd100; corr[90] = -16'sd5;
    run("signed", 86, 95, 1'b0 ^ 1'b1, 88, 0, 2*10+2, 0);

    // Equal pair at 60,61: f=-2 and f=-1 tie, -2 kept -> (60, +1)
    clr(); corr[60] = 16'sh1000; corr[61] = 16'sh1000;
    run("remap_m2", 50, 70, 1'b0, 60, 1, 2*21+88, 0);

    // -4096,4096,4000 at 69..71: f=2 (5646) beats f=1 (5496) -> (71, -1)
    clr(); corr[69] = -16'sd4096; corr[70] = 16'sd4096; corr[71] = 16'sd4000;
    run("remap_p2", 60, 80, 1'b0, 71, -1, 2*21+88, 0);

    // All 0x7FFF: L_mac saturates, f=0 rounds to 30054, others 25205
    clr(); for (int i = 36; i <= 54; i++) corr[i] = 16'sh7FFF;
    run("sat", 40, 50, 1'b0, 50, 0, 2*11+88, 0);

    // Reset in the middle of interpolation
    clr(); corr[50] = 16'sh4000;
    cur_tmin = 40; t0Min = 16'd40; t0Max = 16'd60; firstSubfr = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst.addr", {20'd0, memReadAddr}, 32'd0);
    chk("midrst.t0", {16'd0, t0}, 32'd0);
    chk("midrst.frac", {16'd0, frac}, 32'd0);
    chk("midrst.done", {31'd0, done}, 32'd0);

    // Restart after reset, with a start pulse while busy that must be ignored
    run("busy", 40, 60, 1'b0, 50, 0, 2*21+88, 10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
